// File: rtl/tans_hf_recoder.sv
// tans_hf_recoder: decodes an L=8 tANS stream (A/B/C, counts 4/2/2) read last-written-first
// and re-emits each symbol as a padded Huffman code; returns the recovered initial encoder state.
module tans_hf_recoder #(
    parameter int MAX_SYMS = 255
) (
    input  logic       PHI,
    input  logic       RST_N,
    input  logic       I_F,
    input  logic [3:0] init_state,
    input  logic [7:0] n_syms,
    input  logic       i_valid,
    input  logic [1:0] i_stream,
    input  logic       o_rdy,
    output logic [1:0] BTR,
    output logic       o_valid,
    output logic [1:0] o_stream,
    output logic [1:0] o_len,
    output logic       done,
    output logic [3:0] final_state
);
    typedef enum logic [1:0] {IDLE, DECODE, FIN} fsm_t;
    fsm_t       fsm, fsm_nx;
    logic [3:0] st, st_nx, st_step, base;
    logic [7:0] cnt, cnt_nx;
    logic       ov_nx, step;
    logic [1:0] os_nx, ol_nx, nb, bits, code;
    // Even states decode A (1 bit); odd states decode B/C (2 bits), split on st[1].
    always_comb begin
        nb      = st[0] ? 2'd2 : 2'd1;
        code    = st[0] ? (st[1] ? 2'b11 : 2'b10) : 2'b00;
        base    = st[0] ? (st[2] ? 4'd12 : 4'd8) : st;
        bits    = st[0] ? i_stream : {1'b0, i_stream[0]};
        st_step = base | {2'b00, bits};
        step    = (fsm == DECODE) && i_valid && o_rdy;
    end
    always_comb begin
        fsm_nx = fsm;
        st_nx  = st;
        cnt_nx = cnt;
        ov_nx  = 1'b0;
        os_nx  = o_stream;
        ol_nx  = o_len;
        if (I_F) begin
            st_nx  = {1'b1, init_state[2:0]};
            cnt_nx = n_syms;
            fsm_nx = (n_syms == 8'd0) ? FIN : DECODE;
        end else if (step) begin
            st_nx  = st_step;
            cnt_nx = cnt - 8'd1;
            ov_nx  = 1'b1;
            os_nx  = code;
            ol_nx  = nb;
            fsm_nx = (cnt == 8'd1) ? FIN : DECODE;
        end
    end
    always_ff @(posedge PHI or negedge RST_N) begin
        if (!RST_N) begin
            fsm      <= IDLE;
            st       <= 4'd8;
            cnt      <= 8'd0;
            o_valid  <= 1'b0;
            o_stream <= 2'b00;
            o_len    <= 2'd0;
        end else begin
            fsm      <= fsm_nx;
            st       <= st_nx;
            cnt      <= cnt_nx;
            o_valid  <= ov_nx;
            o_stream <= os_nx;
            o_len    <= ol_nx;
        end
    end
    assign BTR         = (fsm == DECODE) ? nb : 2'd0;
    assign done        = (fsm == FIN);
    assign final_state = (fsm == FIN) ? st : 4'd0;
endmodule

// File: tb/tb_tans_hf_recoder.sv
// tb_tans_hf_recoder: directed vectors with a scoreboard queue checked by an output monitor.
module tb_tans_hf_recoder;
    logic       PHI = 1'b0, RST_N = 1'b0, I_F = 1'b0, i_valid = 1'b0, o_rdy = 1'b1;
    logic [3:0] init_state = 4'd0;
    logic [7:0] n_syms = 8'd0;
    logic [1:0] i_stream = 2'd0;
    logic [1:0] BTR, o_stream, o_len;
    logic       o_valid, done;
    logic [3:0] final_state;
    int         tests = 0, fails = 0;
    logic [3:0] q[$];
    logic [3:0] exp_sym;
    localparam logic [3:0] SA = 4'b0001, SB = 4'b1010, SC = 4'b1110;

    tans_hf_recoder dut (
        .PHI(PHI), .RST_N(RST_N), .I_F(I_F), .init_state(init_state), .n_syms(n_syms),
        .i_valid(i_valid), .i_stream(i_stream), .o_rdy(o_rdy), .BTR(BTR), .o_valid(o_valid),
        .o_stream(o_stream), .o_len(o_len), .done(done), .final_state(final_state)
    );

    always #5 PHI = ~PHI;

    always @(negedge PHI) begin
        if (RST_N && o_valid) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL sym_unexpected: got code=%b len=%0d, required no o_valid", o_stream, o_len);
            end else begin
                exp_sym = q.pop_front();
                if ({o_stream, o_len} !== exp_sym) begin
                    fails++;
                    $display("FAIL sym: got code=%b len=%0d, required code=%b len=%0d",
                             o_stream, o_len, exp_sym[3:2], exp_sym[1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] s, input logic [7:0] n);
        @(negedge PHI);
        I_F = 1'b1; init_state = s; n_syms = n;
        @(posedge PHI);
        #1 I_F = 1'b0;
    endtask

    task automatic step(input logic [1:0] b, input logic [3:0] sym, input logic [1:0] btr);
        @(negedge PHI);
        check("btr", {6'd0, BTR}, {6'd0, btr});
        i_valid = 1'b1; o_rdy = 1'b1; i_stream = b;
        q.push_back(sym);
        @(posedge PHI);
    endtask

    task automatic quiet();
        @(negedge PHI);
        i_valid = 1'b0;
    endtask

    task automatic finish_chk(input logic [3:0] fs);
        check("done", {7'd0, done}, 8'd1);
        check("final_state", {4'd0, final_state}, {4'd0, fs});
        check("btr_done", {6'd0, BTR}, 8'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge PHI);
        check("drain", 8'(q.size()), 8'd0);
    endtask

    initial begin
        #12;
        check("rst_btr", {6'd0, BTR}, 8'd0);
        check("rst_ovalid", {7'd0, o_valid}, 8'd0);
        check("rst_ostream", {6'd0, o_stream}, 8'd0);
        check("rst_olen", {6'd0, o_len}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_final", {4'd0, final_state}, 8'd0);
        RST_N = 1'b1;
        // basic decode, back-to-back
        load(4'd9, 8'd3);
        check("basic_done0", {7'd0, done}, 8'd0);
        step(2'b11, SB, 2'd2);
        step(2'b01, SC, 2'd2);
        step(2'b00, SB, 2'd2);
        quiet();
        finish_chk(4'd8);
        // single A, upper bit must be ignored
        load(4'd8, 8'd1);
        step(2'b11, SA, 2'd1);
        quiet();
        finish_chk(4'd9);
        // stall before the second symbol
        load(4'd9, 8'd3);
        step(2'b11, SB, 2'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge PHI);
            o_rdy = 1'b0; i_stream = 2'b01;
            check("stall_btr", {6'd0, BTR}, 8'd2);
            check("stall_done", {7'd0, done}, 8'd0);
        end
        step(2'b01, SC, 2'd2);
        step(2'b00, SB, 2'd2);
        quiet();
        finish_chk(4'd8);
        // i_valid in DONE is ignored
        @(negedge PHI) i_valid = 1'b1;
        quiet();
        finish_chk(4'd8);
        // zero count
        load(4'd13, 8'd0);
        @(negedge PHI);
        finish_chk(4'd13);
        // restart mid-decode
        load(4'd9, 8'd3);
        step(2'b11, SB, 2'd2);
        quiet();
        load(4'd14, 8'd1);
        @(negedge PHI);
        check("restart_done", {7'd0, done}, 8'd0);
        step(2'b00, SA, 2'd1);
        quiet();
        finish_chk(4'd14);
        // round trip: B A A A C B A A
        load(4'd9, 8'd8);
        step(2'b10, SB, 2'd2);
        step(2'b10, SA, 2'd1);
        step(2'b00, SA, 2'd1);
        step(2'b01, SA, 2'd1);
        step(2'b01, SC, 2'd2);
        step(2'b00, SB, 2'd2);
        step(2'b00, SA, 2'd1);
        step(2'b00, SA, 2'd1);
        quiet();
        finish_chk(4'd8);
        drain();
        // asynchronous reset mid-decode
        load(4'd9, 8'd3);
        step(2'b11, SB, 2'd2);
        #2 RST_N = 1'b0;
        #1;
        check("arst_ovalid", {7'd0, o_valid}, 8'd0);
        check("arst_btr", {6'd0, BTR}, 8'd0);
        check("arst_ostream", {6'd0, o_stream}, 8'd0);
        check("arst_done", {7'd0, done}, 8'd0);
        q.delete();
        i_valid = 1'b0;
        repeat (2) @(negedge PHI);
        RST_N = 1'b1;
        repeat (2) @(negedge PHI);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
